// File: rtl/ysyx_23060201_mem_arbiter_pkg.sv
// ysyx_23060201_mem_arbiter_pkg: state encodings and owner ids shared by the data-memory arbiter.
package ysyx_23060201_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        YSYX_23060201_IDLE = 2'd0,
        YSYX_23060201_REQ  = 2'd1,
        YSYX_23060201_RESP = 2'd2
    } ysyx_23060201_state_t;

    localparam logic YSYX_23060201_OWNER_IFU = 1'b0;
    localparam logic YSYX_23060201_OWNER_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060201_timeout_cnt.sv
// ysyx_23060201_timeout_cnt: per-transaction watchdog, hit flags the last cycle before a forced error.
module ysyx_23060201_timeout_cnt #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    // The accept cycle itself counts, so the error pulse lands TIMEOUT cycles after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clear) cnt <= W'(1);
        else if (enable) cnt <= cnt + W'(1);
    end

    assign hit = cnt == W'(TIMEOUT - 1);

endmodule

// File: rtl/ysyx_23060201_mem_arbiter.sv
// ysyx_23060201_mem_arbiter: round-robin share of one data-memory port between IFU and LSU.
module ysyx_23060201_mem_arbiter
    import ysyx_23060201_mem_arbiter_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT        = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ifu_req_valid,
    output logic                      ifu_req_ready,
    input  logic [MEM_ADDR_WIDTH-1:0] ifu_req_addr,
    output logic                      ifu_resp_valid,
    output logic [DATA_WIDTH-1:0]     ifu_resp_data,
    output logic                      ifu_resp_err,
    input  logic                      lsu_req_valid,
    output logic                      lsu_req_ready,
    input  logic                      lsu_req_wen,
    input  logic [MEM_ADDR_WIDTH-1:0] lsu_req_addr,
    input  logic [DATA_WIDTH-1:0]     lsu_req_wdata,
    input  logic [7:0]                lsu_req_wmask,
    output logic                      lsu_resp_valid,
    output logic [DATA_WIDTH-1:0]     lsu_resp_rdata,
    output logic                      lsu_resp_err,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_wen,
    output logic [MEM_ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0]     mem_req_wdata,
    output logic [7:0]                mem_req_wmask,
    input  logic                      mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_resp_rdata,
    input  logic                      mem_resp_err
);

    ysyx_23060201_state_t state, state_n;

    logic last_grant, owner;
    logic grant_ifu, grant_lsu, accept;
    logic done, resp_ok, done_err, cnt_en, timeout_hit;

    // Readies are gated by rst_n so that every output is low while reset is held.
    assign grant_ifu = rst_n && state == YSYX_23060201_IDLE && ifu_req_valid &&
                       (!lsu_req_valid || last_grant == YSYX_23060201_OWNER_LSU);
    assign grant_lsu = rst_n && state == YSYX_23060201_IDLE && lsu_req_valid && !grant_ifu;
    assign accept    = grant_ifu || grant_lsu;

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;

    assign resp_ok  = state == YSYX_23060201_RESP && mem_resp_valid;
    assign done_err = resp_ok ? mem_resp_err : 1'b1;

    ysyx_23060201_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .enable(cnt_en),
        .hit   (timeout_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= YSYX_23060201_IDLE;
        else state <= state_n;
    end

    // A real response in the same cycle as the watchdog hit takes priority.
    always_comb begin
        state_n       = state;
        mem_req_valid = 1'b0;
        done          = 1'b0;
        cnt_en        = 1'b0;
        case (state)
            YSYX_23060201_IDLE: state_n = accept ? YSYX_23060201_REQ : YSYX_23060201_IDLE;
            YSYX_23060201_REQ: begin
                mem_req_valid = 1'b1;
                cnt_en        = 1'b1;
                done          = timeout_hit;
                state_n       = timeout_hit   ? YSYX_23060201_IDLE :
                                mem_req_ready ? YSYX_23060201_RESP : YSYX_23060201_REQ;
            end
            YSYX_23060201_RESP: begin
                cnt_en  = 1'b1;
                done    = mem_resp_valid || timeout_hit;
                state_n = done ? YSYX_23060201_IDLE : YSYX_23060201_RESP;
            end
            default: state_n = YSYX_23060201_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant    <= YSYX_23060201_OWNER_LSU;
            owner         <= YSYX_23060201_OWNER_IFU;
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
        end else if (accept) begin
            last_grant    <= grant_lsu;
            owner         <= grant_lsu;
            mem_req_wen   <= grant_lsu && lsu_req_wen;
            mem_req_addr  <= grant_lsu ? lsu_req_addr : ifu_req_addr;
            mem_req_wdata <= grant_lsu ? lsu_req_wdata : '0;
            mem_req_wmask <= grant_lsu ? lsu_req_wmask : 8'h0f;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifu_resp_valid <= 1'b0;
            ifu_resp_data  <= '0;
            ifu_resp_err   <= 1'b0;
            lsu_resp_valid <= 1'b0;
            lsu_resp_rdata <= '0;
            lsu_resp_err   <= 1'b0;
        end else begin
            ifu_resp_valid <= done && owner == YSYX_23060201_OWNER_IFU;
            ifu_resp_data  <= (done && owner == YSYX_23060201_OWNER_IFU && resp_ok) ? mem_resp_rdata : '0;
            ifu_resp_err   <= done && owner == YSYX_23060201_OWNER_IFU && done_err;
            lsu_resp_valid <= done && owner == YSYX_23060201_OWNER_LSU;
            lsu_resp_rdata <= (done && owner == YSYX_23060201_OWNER_LSU && resp_ok && !mem_req_wen) ?
                              mem_resp_rdata : '0;
            lsu_resp_err   <= done && owner == YSYX_23060201_OWNER_LSU && done_err;
        end
    end

endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// tb_ysyx_23060201_mem_arbiter: directed checks of grant order, latching, timeout and reset.
module tb_ysyx_23060201_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req_valid = 1'b0, ifu_req_ready;
    logic [31:0] ifu_req_addr = '0;
    logic        ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_resp_data;
    logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_req_wen = 1'b0;
    logic [31:0] lsu_req_addr = '0, lsu_req_wdata = '0;
    logic [7:0]  lsu_req_wmask = '0;
    logic        lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_resp_rdata;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid = 1'b0, mem_resp_err = 1'b0;
    logic [31:0] mem_resp_rdata = '0;

    int total = 0;
    int bad = 0;

    ysyx_23060201_mem_arbiter #(
        .MEM_ADDR_WIDTH(32),
        .DATA_WIDTH    (32),
        .TIMEOUT       (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid),
        .ifu_resp_data (ifu_resp_data),
        .ifu_resp_err  (ifu_resp_err),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_req_wen   (lsu_req_wen),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_req_wmask (lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid),
        .lsu_resp_rdata(lsu_resp_rdata),
        .lsu_resp_err  (lsu_resp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_wen   (mem_req_wen),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata),
        .mem_resp_err  (mem_resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1;
        chk("rst_ifu_resp_valid", 64'(ifu_resp_valid), 0);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 0);
        chk("rst_mem_req_addr", 64'(mem_req_addr), 0);
        chk("rst_lsu_resp_valid", 64'(lsu_resp_valid), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Test 1: lone IFU fetch
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; mem_req_ready = 1'b1;
        #1;
        chk("t1_ifu_ready", 64'(ifu_req_ready), 1);
        chk("t1_lsu_ready", 64'(lsu_req_ready), 0);
        chk("t1_memv_c0", 64'(mem_req_valid), 0);
        tick;
        ifu_req_valid = 1'b0;
        #1;
        chk("t1_memv_c1", 64'(mem_req_valid), 1);
        chk("t1_mem_addr", 64'(mem_req_addr), 64'h8000_0000);
        chk("t1_mem_wen", 64'(mem_req_wen), 0);
        chk("t1_mem_wmask", 64'(mem_req_wmask), 64'h0f);
        tick;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0000_0413;
        #1;
        chk("t1_memv_c2", 64'(mem_req_valid), 0);
        chk("t1_respv_c2", 64'(ifu_resp_valid), 0);
        tick;
        mem_resp_valid = 1'b0;
        #1;
        chk("t1_respv", 64'(ifu_resp_valid), 1);
        chk("t1_resp_data", 64'(ifu_resp_data), 64'h413);
        chk("t1_resp_err", 64'(ifu_resp_err), 0);
        chk("t1_lsu_respv", 64'(lsu_resp_valid), 0);
        tick;
        chk("t1_respv_end", 64'(ifu_resp_valid), 0);

        // Test 2: both valid continuously after a fresh reset alternate IFU, LSU, ...
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_req_wen = 1'b0;
        lsu_req_wmask = 8'h0f; mem_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_resp_valid = 1'b0;
            #1;
            if (k > 0) begin
                chk("t2_ifu_respv", 64'(ifu_resp_valid), 64'(k % 2 == 1));
                chk("t2_lsu_respv", 64'(lsu_resp_valid), 64'(k % 2 == 0));
            end
            chk("t2_ifu_ready", 64'(ifu_req_ready), 64'(k % 2 == 0));
            chk("t2_lsu_ready", 64'(lsu_req_ready), 64'(k % 2 == 1));
            tick;
            chk("t2_no_ready_req", 64'({ifu_req_ready, lsu_req_ready}), 0);
            tick;
            mem_resp_valid = 1'b1; mem_resp_rdata = 32'h100 + 32'(k);
            tick;
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_resp_valid = 1'b0;
        #1;
        chk("t2_last_lsu_respv", 64'(lsu_resp_valid), 1);
        chk("t2_last_lsu_rdata", 64'(lsu_resp_rdata), 64'h103);
        tick;

        // Test 3: LSU store stalled by memory for 5 cycles; response lands on the watchdog cycle
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 32'h8000_0100;
        lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 8'h03; mem_req_ready = 1'b0;
        #1;
        chk("t3_lsu_ready", 64'(lsu_req_ready), 1);
        tick;
        lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wdata = '0; lsu_req_wmask = '0;
        for (int c = 1; c <= 6; c++) begin
            mem_req_ready = (c == 6);
            #1;
            chk("t3_memv", 64'(mem_req_valid), 1);
            chk("t3_fields", {mem_req_wen, mem_req_wmask, mem_req_addr[22:0], mem_req_wdata},
                {1'b1, 8'h03, 23'h00_0100, 32'hDEAD_BEEF});
            tick;
        end
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1234_5678; mem_resp_err = 1'b0;
        tick;
        mem_resp_valid = 1'b0;
        #1;
        chk("t3_lsu_respv", 64'(lsu_resp_valid), 1);
        chk("t3_lsu_rdata", 64'(lsu_resp_rdata), 0);
        chk("t3_lsu_err", 64'(lsu_resp_err), 0);
        chk("t3_ifu_respv", 64'(ifu_resp_valid), 0);
        tick;

        // Test 4: load never answered -> forced error 8 cycles after accept
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 32'h8000_0200;
        lsu_req_wmask = 8'h0f; mem_req_ready = 1'b1;
        #1;
        chk("t4_lsu_ready", 64'(lsu_req_ready), 1);
        tick;
        lsu_req_valid = 1'b0;
        tick;
        mem_req_ready = 1'b0;
        for (int c = 2; c < 8; c++) begin
            #1;
            chk("t4_no_resp_yet", 64'(lsu_resp_valid), 0);
            tick;
        end
        #1;
        chk("t4_to_respv", 64'(lsu_resp_valid), 1);
        chk("t4_to_err", 64'(lsu_resp_err), 1);
        chk("t4_to_rdata", 64'(lsu_resp_rdata), 0);
        chk("t4_memv", 64'(mem_req_valid), 0);
        tick;
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFF_FFFF;
        tick;
        mem_resp_valid = 1'b0;
        #1;
        chk("t4_stray_dropped", 64'({lsu_resp_valid, ifu_resp_valid}), 0);
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0004; mem_req_ready = 1'b1;
        #1;
        chk("t4_ifu_ready", 64'(ifu_req_ready), 1);
        tick;
        ifu_req_valid = 1'b0;
        #1;
        chk("t4_ifu_addr", 64'(mem_req_addr), 64'h8000_0004);
        tick;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0010_0073;
        tick;
        mem_resp_valid = 1'b0;
        #1;
        chk("t4_ifu_respv", 64'(ifu_resp_valid), 1);
        chk("t4_ifu_data", 64'(ifu_resp_data), 64'h0010_0073);
        chk("t4_ifu_err", 64'(ifu_resp_err), 0);
        tick;

        // Test 5: reset while in RESP; after release IFU wins the tie again
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0008; mem_req_ready = 1'b1;
        tick;
        ifu_req_valid = 1'b0;
        tick;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; mem_req_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_readys", 64'({ifu_req_ready, lsu_req_ready}), 0);
        chk("t5_rst_addr", 64'(mem_req_addr), 0);
        chk("t5_rst_wmask", 64'(mem_req_wmask), 0);
        chk("t5_rst_resp", 64'({ifu_resp_valid, lsu_resp_valid, mem_req_valid}), 0);
        tick;
        rst_n = 1'b1;
        #1;
        chk("t5_ifu_wins", 64'(ifu_req_ready), 1);
        chk("t5_lsu_loses", 64'(lsu_req_ready), 0);
        mem_req_ready = 1'b1;
        tick;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        #1;
        chk("t5_req_addr", 64'(mem_req_addr), 64'h8000_0008);
        tick;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0000_0013;
        tick;
        mem_resp_valid = 1'b0;
        #1;
        chk("t5_ifu_respv", 64'(ifu_resp_valid), 1);
        tick;

        // Test 6: load with bus error passes data and error through
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 32'h8000_0300; lsu_req_wmask = 8'h01;
        #1;
        chk("t6_lsu_ready", 64'(lsu_req_ready), 1);
        tick;
        lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        chk("t6_mem_wmask", 64'(mem_req_wmask), 64'h01);
        tick;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hA5A5_A5A5; mem_resp_err = 1'b1;
        tick;
        mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
        #1;
        chk("t6_lsu_respv", 64'(lsu_resp_valid), 1);
        chk("t6_lsu_err", 64'(lsu_resp_err), 1);
        chk("t6_lsu_rdata", 64'(lsu_resp_rdata), 64'hA5A5_A5A5);
        chk("t6_ifu_respv", 64'(ifu_resp_valid), 0);
        tick;
        chk("t6_pulse_one_cycle", 64'(lsu_resp_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
